// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control path: pc source select,
// branch condition field and run/halt state.
package cpu_pkg;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_ABS = 2'b10;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } run_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a branch condition field against the Z/N/V status flags.
// Unassigned encodings never take.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_AL: take = 1'b1;
            COND_EQ: take = z;
            COND_NE: take = ~z;
            COND_LT: take = n ^ v;
            COND_LE: take = (n ^ v) | z;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_addr_unit.sv
// Program counter, link register and data-address register with
// relative/absolute branching, run/halt control and a taken-branch counter.
module pc_addr_unit
    import cpu_pkg::*;
#(
    parameter int             AW        = 9,
    parameter logic [AW-1:0]  RESET_VEC = '0,
    parameter int             CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reset_pc,
    input  logic          load_pc,
    input  logic [1:0]    pc_sel,
    input  logic [2:0]    cond,
    input  logic          Z,
    input  logic          N,
    input  logic          V,
    input  logic [15:0]   sximm8,
    input  logic [AW-1:0] target,
    input  logic          load_link,
    input  logic          halt,
    input  logic          load_addr,
    input  logic [AW-1:0] addr_in,
    input  logic          addr_sel,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] link,
    output logic [AW-1:0] mem_addr,
    output logic          halted,
    output logic          taken,
    output logic [CW-1:0] taken_count
);

    localparam logic [AW-1:0] PC_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    run_state_t    state;
    run_state_t    state_next;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] offset;
    logic [AW-1:0] pc_next;
    logic          cond_true;
    logic          br_taken;
    logic          count_en;

    branch_cond_eval u_cond (
        .cond (cond),
        .z    (Z),
        .n    (N),
        .v    (V),
        .take (cond_true)
    );

    // Offset is sign-extended or truncated to the address width.
    assign offset = AW'($signed(sximm8));

    always_comb begin
        pc_next  = pc + PC_ONE;
        br_taken = 1'b0;
        case (pc_sel)
            PC_REL: begin
                if (cond_true) begin
                    pc_next  = pc + offset;
                    br_taken = 1'b1;
                end
            end
            PC_ABS: begin
                pc_next  = target;
                br_taken = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    assign count_en = load_pc & br_taken & (taken_count != CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_VEC;
            link        <= '0;
            addr_q      <= '0;
            state       <= RUN;
            taken       <= 1'b0;
            taken_count <= '0;
        end else begin
            if (load_addr) addr_q <= addr_in;
            if (reset_pc) begin
                pc    <= RESET_VEC;
                state <= RUN;
                taken <= 1'b0;
            end else if (state == HALT) begin
                taken <= 1'b0;
            end else begin
                state <= state_next;
                taken <= load_pc & br_taken;
                if (load_pc) pc <= pc_next;
                if (load_link) link <= pc;
                if (count_en) taken_count <= taken_count + CNT_ONE;
            end
        end
    end

    assign halted   = (state == HALT);
    assign mem_addr = addr_sel ? pc : addr_q;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Scoreboard bench for pc_addr_unit: directed scenarios then random
// traffic against an arithmetic reference model.
module tb_pc_addr_unit;

    localparam int AW = 9;
    localparam int CW = 2;
    localparam int AMOD = 512;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reset_pc = 1'b0;
    logic          load_pc = 1'b0;
    logic [1:0]    pc_sel = '0;
    logic [2:0]    cond = '0;
    logic          Z = 1'b0;
    logic          N = 1'b0;
    logic          V = 1'b0;
    logic [15:0]   sximm8 = '0;
    logic [AW-1:0] target = '0;
    logic          load_link = 1'b0;
    logic          halt = 1'b0;
    logic          load_addr = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic          addr_sel = 1'b0;
    logic [AW-1:0] pc;
    logic [AW-1:0] link;
    logic [AW-1:0] mem_addr;
    logic          halted;
    logic          taken;
    logic [CW-1:0] taken_count;

    pc_addr_unit #(.AW(AW), .RESET_VEC('0), .CW(CW)) dut (
        .clk(clk), .reset(reset), .reset_pc(reset_pc),
        .load_pc(load_pc), .pc_sel(pc_sel), .cond(cond),
        .Z(Z), .N(N), .V(V), .sximm8(sximm8), .target(target),
        .load_link(load_link), .halt(halt), .load_addr(load_addr),
        .addr_in(addr_in), .addr_sel(addr_sel), .pc(pc), .link(link),
        .mem_addr(mem_addr), .halted(halted), .taken(taken),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst, rpc, lpc;
        bit [1:0] sel;
        bit [2:0] cnd;
        bit       z, n, v;
        bit [15:0] imm;
        int       tgt;
        bit       llink, hlt, laddr;
        int       ain;
        bit       asel;
    } stim_t;

    typedef struct {
        int pc, link, halted, taken, cnt, maddr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int m_pc = 0, m_link = 0, m_addr = 0, m_halted = 0;
    int m_taken = 0, m_cnt = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit cond_ok(int c, bit z, bit n, bit v);
        bit lt;
        lt = (n != v);
        if (c == 0) return 1;
        if (c == 1) return z;
        if (c == 2) return !z;
        if (c == 3) return lt;
        if (c == 4) return lt || z;
        return 0;
    endfunction

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model(input stim_t s);
        int np, off;
        bit tk;
        if (s.rst) begin
            m_pc = 0; m_link = 0; m_addr = 0;
            m_halted = 0; m_taken = 0; m_cnt = 0;
            return;
        end
        if (s.laddr) m_addr = s.ain;
        if (s.rpc) begin
            m_pc = 0; m_halted = 0; m_taken = 0;
        end else if (m_halted != 0) begin
            m_taken = 0;
        end else begin
            off = $signed(s.imm);
            tk = 0;
            np = m_pc + 1;
            if (s.sel == 1 && cond_ok(s.cnd, s.z, s.n, s.v)) begin
                np = m_pc + off; tk = 1;
            end else if (s.sel == 2) begin
                np = s.tgt; tk = 1;
            end
            np = ((np % AMOD) + AMOD) % AMOD;
            tk = tk && s.lpc;
            if (s.llink) m_link = m_pc;
            if (s.lpc) m_pc = np;
            m_taken = tk;
            if (tk && m_cnt < CMAX) m_cnt++;
            if (s.hlt) m_halted = 1;
        end
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset = s.rst; reset_pc = s.rpc; load_pc = s.lpc;
        pc_sel = s.sel; cond = s.cnd; Z = s.z; N = s.n; V = s.v;
        sximm8 = s.imm; target = AW'(s.tgt); load_link = s.llink;
        halt = s.hlt; load_addr = s.laddr; addr_in = AW'(s.ain);
        addr_sel = s.asel;
        model(s);
        e.pc = m_pc; e.link = m_link; e.halted = m_halted;
        e.taken = m_taken; e.cnt = m_cnt;
        e.maddr = s.asel ? m_pc : m_addr;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", int'(pc), e.pc);
                chk("link", int'(link), e.link);
                chk("halted", int'(halted), e.halted);
                chk("taken", int'(taken), e.taken);
                chk("taken_count", int'(taken_count), e.cnt);
                chk("mem_addr", int'(mem_addr), e.maddr);
            end
        end
    end

    stim_t s;

    initial begin
        s = idle(); apply(s);
        s.sel = 2'b10; s.lpc = 1; s.tgt = 'h55; apply(s);
        // Async reset mid-cycle, observed before the next edge.
        @(posedge clk); #3; reset = 1'b1; #1;
        chk("async_pc", int'(pc), 0);
        chk("async_taken", int'(taken), 0);
        chk("async_cnt", int'(taken_count), 0);
        model('{rst: 1, default: 0});
        s = idle(); apply(s);
        s = idle(); s.lpc = 1;
        repeat (3) apply(s);
        s = idle(); s.lpc = 1; s.sel = 2'b10; s.tgt = 5; apply(s);
        s = idle(); s.lpc = 1; s.sel = 2'b01; s.cnd = 3'b001;
        s.z = 1; s.imm = 16'hFFFD; apply(s);
        s.z = 0; apply(s);
        s = idle(); s.lpc = 1; s.sel = 2'b10; s.tgt = 511; apply(s);
        s = idle(); s.lpc = 1; apply(s);
        s = idle(); s.lpc = 1; s.sel = 2'b10; s.tgt = 7; apply(s);
        s.tgt = 'h1A0; s.llink = 1; apply(s);
        s = idle(); s.lpc = 1; s.sel = 2'b10; s.tgt = 4; apply(s);
        s = idle(); s.lpc = 1; s.hlt = 1; apply(s);
        s = idle(); s.lpc = 1; s.sel = 2'b10; s.tgt = 'h33;
        s.llink = 1; apply(s);
        s = idle(); s.laddr = 1; s.ain = 'h0AB; apply(s);
        s = idle(); s.rpc = 1; s.lpc = 1; s.sel = 2'b10; s.tgt = 9; apply(s);
        s = idle(); s.asel = 1; apply(s);
        s = idle(); s.asel = 1; s.lpc = 1; apply(s);
        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 49) == 0);
            s.rpc   = ($urandom_range(0, 19) == 0);
            s.hlt   = ($urandom_range(0, 14) == 0);
            s.lpc   = $urandom_range(0, 1);
            s.sel   = 2'($urandom_range(0, 3));
            s.cnd   = 3'($urandom_range(0, 7));
            s.z     = $urandom_range(0, 1);
            s.n     = $urandom_range(0, 1);
            s.v     = $urandom_range(0, 1);
            s.imm   = 16'($signed(8'($urandom_range(0, 255))));
            s.tgt   = $urandom_range(0, AMOD - 1);
            s.llink = $urandom_range(0, 1);
            s.laddr = $urandom_range(0, 1);
            s.ain   = $urandom_range(0, AMOD - 1);
            s.asel  = $urandom_range(0, 1);
            apply(s);
        end
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
